// File: rtl/caesar_display_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : caesar_display_sequencer
// Description : Message buffer with Caesar shift; plays one shifted letter per
//               2**TICK_W clocks to the digit decoder under start/done control.
// Revision    : 1.0
// ============================================================================
module caesar_display_sequencer #(
    parameter int TICK_W = 25,
    parameter int DEPTH  = 8,
    parameter int IDX_W  = 3
) (
    input  logic             CLOCK_50,
    input  logic             Resetn,
    input  logic             wr_en,
    input  logic [4:0]       wr_data,
    input  logic             clear,
    input  logic             start,
    input  logic             decrypt,
    input  logic [4:0]       key,
    output logic             wr_full,
    output logic             busy,
    output logic             done,
    output logic             char_valid,
    output logic [4:0]       char_out,
    output logic [IDX_W-1:0] char_idx
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W:0] C_DEPTH = (IDX_W+1)'(DEPTH);

    state_t             state_q, state_d;
    logic [IDX_W:0]     count_q, count_d;
    logic [TICK_W-1:0]  presc_q, presc_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [4:0]         char_q, char_d;
    logic               valid_q, valid_d;
    logic [4:0]         key_q, key_d;
    logic               dec_q, dec_d;
    logic [4:0]         mem_q [DEPTH];

    logic               wr_fire;
    logic               tick;
    logic               last_letter;
    logic [4:0]         key_mod;
    logic [IDX_W-1:0]   idx_next;
    logic [IDX_W:0]     idx_plus1;

    // Operands are already reduced below 26, so one conditional subtract suffices.
    function automatic logic [4:0] shift_letter(input logic [4:0] c,
                                                input logic [4:0] k,
                                                input logic       dec);
        logic [5:0] sum;
        if (dec) begin
            sum = {1'b0, c} + 6'd26 - {1'b0, k};
        end else begin
            sum = {1'b0, c} + {1'b0, k};
        end
        if (sum >= 6'd26) begin
            sum = sum - 6'd26;
        end
        return 5'(sum);
    endfunction

    assign key_mod     = (key >= 5'd26) ? (key - 5'd26) : key;
    assign tick        = &presc_q;
    assign idx_next    = idx_q + 1'b1;
    assign idx_plus1   = {1'b0, idx_q} + 1'b1;
    assign last_letter = (idx_plus1 == count_q);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        idx_d   = idx_q;
        char_d  = char_q;
        valid_d = valid_q;
        key_d   = key_q;
        dec_d   = dec_q;
        wr_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    count_d = '0;
                end else if (start && (count_q != '0)) begin
                    state_d = ST_RUN;
                    key_d   = key_mod;
                    dec_d   = decrypt;
                    idx_d   = '0;
                    presc_d = '0;
                    valid_d = 1'b1;
                    char_d  = shift_letter(mem_q[0], key_mod, decrypt);
                end else if (wr_en && (wr_data <= 5'd25) && (count_q != C_DEPTH)) begin
                    wr_fire = 1'b1;
                    count_d = count_q + 1'b1;
                end
            end
            ST_RUN: begin
                presc_d = presc_q + 1'b1;
                if (clear) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    valid_d = 1'b0;
                    presc_d = '0;
                end else if (tick) begin
                    if (last_letter) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        presc_d = '0;
                    end else begin
                        idx_d  = idx_next;
                        char_d = shift_letter(mem_q[idx_next], key_q, dec_q);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            presc_q <= '0;
            idx_q   <= '0;
            char_q  <= '0;
            valid_q <= 1'b0;
            key_q   <= '0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            char_q  <= char_d;
            valid_q <= valid_d;
            key_q   <= key_d;
            dec_q   <= dec_d;
        end
    end

    // Buffer storage carries no reset; only entries below count are ever read.
    always_ff @(posedge CLOCK_50) begin
        if (wr_fire) begin
            mem_q[count_q[IDX_W-1:0]] <= wr_data;
        end
    end

    assign wr_full    = (count_q == C_DEPTH);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign char_valid = valid_q;
    assign char_out   = char_q;
    assign char_idx   = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_caesar_display_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_caesar_display_sequencer
// Description : Directed and randomized bench with a time-based playback model.
// Revision    : 1.0
// ============================================================================
module tb_caesar_display_sequencer;

    localparam int TICK_W = 3;
    localparam int DEPTH  = 8;
    localparam int IDX_W  = 3;
    localparam int PER    = 1 << TICK_W;

    logic             clk     = 1'b0;
    logic             Resetn  = 1'b0;
    logic             wr_en   = 1'b0;
    logic [4:0]       wr_data = '0;
    logic             clear   = 1'b0;
    logic             start   = 1'b0;
    logic             decrypt = 1'b0;
    logic [4:0]       key     = '0;
    logic             wr_full;
    logic             busy;
    logic             done;
    logic             char_valid;
    logic [4:0]       char_out;
    logic [IDX_W-1:0] char_idx;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    caesar_display_sequencer #(
        .TICK_W(TICK_W),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) dut (
        .CLOCK_50  (clk),
        .Resetn    (Resetn),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .clear     (clear),
        .start     (start),
        .decrypt   (decrypt),
        .key       (key),
        .wr_full   (wr_full),
        .busy      (busy),
        .done      (done),
        .char_valid(char_valid),
        .char_out  (char_out),
        .char_idx  (char_idx)
    );

    // Model: message queue plus cycles elapsed since playback began (-1 = idle).
    int msg[$];
    int t     = -1;
    int n_let = 0;
    int kk    = 0;
    bit kdec  = 1'b0;

    function automatic int enc(int c);
        if (kdec) return ((c - kk) % 26 + 26) % 26;
        return (c + kk) % 26;
    endfunction

    always @(posedge clk or negedge Resetn) begin
        if (!Resetn) begin
            msg.delete();
            t = -1;
        end else if (t >= 0) begin
            if (t < n_let * PER && clear) begin
                msg.delete();
                t = -1;
            end else if (t == n_let * PER) begin
                t = -1;
            end else begin
                t++;
            end
        end else if (clear) begin
            msg.delete();
        end else if (start && msg.size() > 0) begin
            t     = 0;
            n_let = msg.size();
            kk    = int'(key) % 26;
            kdec  = decrypt;
        end else if (wr_en && int'(wr_data) <= 25 && msg.size() < DEPTH) begin
            msg.push_back(int'(wr_data));
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        bit pv;
        if (Resetn) begin
            pv = (t >= 0) && (t < n_let * PER);
            chk("busy", int'(busy), int'(t >= 0));
            chk("done", int'(done), int'(t >= 0 && t == n_let * PER));
            chk("wr_full", int'(wr_full), int'(msg.size() == DEPTH));
            chk("char_valid", int'(char_valid), int'(pv));
            if (pv) begin
                chk("char_out", int'(char_out), enc(msg[t / PER]));
                chk("char_idx", int'(char_idx), t / PER);
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int d);
        wr_en   = 1'b1;
        wr_data = 5'(d);
        cyc();
        wr_en   = 1'b0;
    endtask

    task automatic go(input int k, input bit d);
        key     = 5'(k);
        decrypt = d;
        start   = 1'b1;
        cyc();
        start   = 1'b0;
    endtask

    task automatic clr();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_valid"}, int'(char_valid), 0);
        chk({tag, "_char"}, int'(char_out), 0);
        chk({tag, "_idx"}, int'(char_idx), 0);
        chk({tag, "_full"}, int'(wr_full), 0);
    endtask

    initial begin
        #22;
        chk_all_zero("reset");
        Resetn = 1'b1;
        cyc();

        // 2,25,0 with +3 -> 5,2,3
        wr(2); wr(25); wr(0);
        go(3, 1'b0);
        chk("enc0_char", int'(char_out), 5);
        chk("enc0_idx", int'(char_idx), 0);
        chk("enc0_valid", int'(char_valid), 1);
        cyc(PER);
        chk("enc1_char", int'(char_out), 2);
        chk("enc1_idx", int'(char_idx), 1);
        cyc(PER);
        chk("enc2_char", int'(char_out), 3);
        chk("enc2_idx", int'(char_idx), 2);
        cyc(PER);
        chk("enc_done", int'(done), 1);
        chk("enc_done_valid", int'(char_valid), 0);
        cyc();
        chk("enc_after_busy", int'(busy), 0);
        chk("enc_after_done", int'(done), 0);

        clr();
        wr(1);
        go(3, 1'b1);
        chk("dec_wrap", int'(char_out), 24);
        cyc(PER + 1);
        clr();
        wr(24);
        go(29, 1'b0);
        chk("key29_wrap", int'(char_out), 1);
        cyc(PER + 1);

        // fill past capacity
        clr();
        for (int i = 0; i < DEPTH; i++) wr((i * 3) % 26);
        chk("full_after_8", int'(wr_full), 1);
        wr(9);
        chk("full_after_9", int'(wr_full), 1);
        go(5, 1'b0);
        chk("full_first", int'(char_out), 5);
        cyc(7 * PER);
        chk("full_last_idx", int'(char_idx), 7);
        chk("full_last_char", int'(char_out), 0);
        cyc(PER);
        chk("full_done", int'(done), 1);
        cyc();

        // invalid code and empty start
        clr();
        wr(27);
        go(0, 1'b0);
        chk("empty_start_busy", int'(busy), 0);

        // clear during second letter
        wr(4); wr(5); wr(6);
        go(1, 1'b0);
        cyc(PER);
        chk("abort_char", int'(char_out), 6);
        chk("abort_idx", int'(char_idx), 1);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("abort_valid", int'(char_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        cyc();
        chk("abort_no_done", int'(done), 0);
        go(1, 1'b0);
        chk("abort_restart_busy", int'(busy), 0);

        // asynchronous reset in the middle of playback
        wr(7); wr(8);
        go(2, 1'b0);
        cyc(10);
        #2;
        Resetn = 1'b0;
        #1;
        chk_all_zero("async");
        cyc(2);
        Resetn = 1'b1;
        go(2, 1'b0);
        chk("post_reset_start", int'(busy), 0);

        for (int i = 0; i < 4000; i++) begin
            wr_en   = ($urandom_range(0, 99) < 40);
            wr_data = 5'($urandom_range(0, 31));
            clear   = ($urandom_range(0, 199) == 0);
            start   = ($urandom_range(0, 99) < 8);
            key     = 5'($urandom_range(0, 31));
            decrypt = 1'($urandom_range(0, 1));
            cyc();
        end
        wr_en = 1'b0;
        clear = 1'b0;
        start = 1'b0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
